// File: rtl/spi_byte_receiver_if.sv
// ---------------------------------------------------------------------------
// spi_byte_receiver_if
// Byte-side bus between the SPI front end and the device controller.
// The receiver drives the received byte stream, transaction status and the
// framing-error strobe, and samples the response byte presented by the
// controller.
//   master : the SPI receiver (produces bytes, consumes tx_data)
//   slave  : the downstream controller
// ---------------------------------------------------------------------------
interface spi_byte_receiver_if #(
   parameter int COUNT_WIDTH = 16
);
   logic [7:0]             tx_data;
   logic [7:0]             data_out;
   logic                   data_out_ready;
   logic                   cs_n_out;
   logic [COUNT_WIDTH-1:0] byte_count;
   logic                   frame_error;

   modport master (
      input  tx_data,
      output data_out,
      output data_out_ready,
      output cs_n_out,
      output byte_count,
      output frame_error
   );

   modport slave (
      output tx_data,
      input  data_out,
      input  data_out_ready,
      input  cs_n_out,
      input  byte_count,
      input  frame_error
   );
endinterface

// File: rtl/spi_byte_receiver.sv
// ---------------------------------------------------------------------------
// spi_byte_receiver
// SPI mode-0 slave front end. The host pins are oversampled in the clk_sys
// domain through SYNC_STAGES-deep synchronizers; edge detectors on the
// synchronized SCLK and CS drive a two-state IDLE/ACTIVE controller that
// assembles bytes MSB first, strobes each completed byte, counts bytes per
// transaction (saturating) and flags CS deasserting mid-byte.
//
// Optional feature macro: SPI_MISO_EN
//   defined   : a TX shift register returns tx_data on spi_miso.
//   undefined : spi_miso is tied low and tx_data is ignored.
//
// After reset the block will not start a transaction until it has seen the
// synchronized CS high, so a CS that is already low at reset release is
// ignored until the host raises and lowers it again.
// ---------------------------------------------------------------------------
module spi_byte_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int COUNT_WIDTH = 16
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic spi_sclk,
   input  logic spi_mosi,
   input  logic spi_cs_n,
   output logic spi_miso,
   spi_byte_receiver_if.master bus
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};
   localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2:0]             WARM_DONE = 3'(SYNC_STAGES);

   // Synchronizer chains, bit 0 is the first stage
   logic [SYNC_STAGES-1:0] sclk_sync_r;
   logic [SYNC_STAGES-1:0] mosi_sync_r;
   logic [SYNC_STAGES-1:0] cs_sync_r;
   logic                   sclk_prev_r;
   logic                   cs_prev_r;

   logic sclk_s;
   logic mosi_s;
   logic cs_s;
   logic sclk_rise_s;
   logic sclk_fall_s;
   logic cs_rise_s;
   logic cs_fall_s;
   logic cs_start_s;

   // Start-of-transaction qualification after reset
   logic [2:0] warm_cnt_r;
   logic       armed_r;

   // Controller state and datapath
   state_t                 state_r;
   state_t                 state_nxt_s;
   logic [2:0]             bit_cnt_r;
   logic [7:0]             shift_r;
   logic [7:0]             data_out_r;
   logic                   data_out_ready_r;
   logic [COUNT_WIDTH-1:0] byte_count_r;
   logic                   frame_error_r;
   logic                   bit_rise_s;
   logic                   byte_done_s;

   // Input synchronizers: reset to idle bus levels (SCLK low, CS high)
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sclk_sync_r <= {SYNC_STAGES{1'b0}};
         mosi_sync_r <= {SYNC_STAGES{1'b0}};
         cs_sync_r   <= {SYNC_STAGES{1'b1}};
         sclk_prev_r <= 1'b0;
         cs_prev_r   <= 1'b1;
      end else begin
         sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], spi_sclk};
         mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], spi_mosi};
         cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], spi_cs_n};
         sclk_prev_r <= sclk_sync_r[SYNC_STAGES-1];
         cs_prev_r   <= cs_sync_r[SYNC_STAGES-1];
      end
   end

   assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
   assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
   assign cs_s        = cs_sync_r[SYNC_STAGES-1];
   assign sclk_rise_s = sclk_s & ~sclk_prev_r;
   assign sclk_fall_s = ~sclk_s & sclk_prev_r;
   assign cs_rise_s   = cs_s & ~cs_prev_r;
   assign cs_fall_s   = ~cs_s & cs_prev_r;

   // Arm only once the synchronizers hold real pin levels and CS reads high
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         warm_cnt_r <= 3'd0;
         armed_r    <= 1'b0;
      end else begin
         if (warm_cnt_r != WARM_DONE) begin
            warm_cnt_r <= warm_cnt_r + 3'd1;
         end else begin
            warm_cnt_r <= warm_cnt_r;
         end
         if ((warm_cnt_r == WARM_DONE) && cs_s) begin
            armed_r <= 1'b1;
         end else begin
            armed_r <= armed_r;
         end
      end
   end

   assign cs_start_s = cs_fall_s & armed_r;

   // A CS rise in the same cycle as an SCLK rise drops that bit
   always_comb begin
      bit_rise_s  = 1'b0;
      byte_done_s = 1'b0;
      if ((state_r == ST_ACTIVE) && sclk_rise_s && !cs_rise_s) begin
         bit_rise_s  = 1'b1;
         byte_done_s = (bit_cnt_r == 3'd7);
      end else begin
         bit_rise_s  = 1'b0;
         byte_done_s = 1'b0;
      end
   end

   // Controller state register
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Controller next-state: IDLE until a qualified CS fall, ACTIVE until CS rises
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (cs_start_s) begin
               state_nxt_s = ST_ACTIVE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_ACTIVE: begin
            if (cs_rise_s) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ACTIVE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Byte assembly, completion strobe, byte counter and framing error
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         bit_cnt_r        <= 3'd0;
         shift_r          <= 8'h00;
         data_out_r       <= 8'h00;
         data_out_ready_r <= 1'b0;
         byte_count_r     <= {COUNT_WIDTH{1'b0}};
         frame_error_r    <= 1'b0;
      end else begin
         data_out_ready_r <= 1'b0;
         frame_error_r    <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (cs_start_s) begin
                  bit_cnt_r    <= 3'd0;
                  shift_r      <= 8'h00;
                  byte_count_r <= {COUNT_WIDTH{1'b0}};
               end else begin
                  bit_cnt_r    <= bit_cnt_r;
                  shift_r      <= shift_r;
                  byte_count_r <= byte_count_r;
               end
            end
            ST_ACTIVE: begin
               if (cs_rise_s) begin
                  // partial byte is dropped; only flag it
                  frame_error_r <= (bit_cnt_r != 3'd0);
               end else if (bit_rise_s) begin
                  shift_r   <= {shift_r[6:0], mosi_s};
                  bit_cnt_r <= bit_cnt_r + 3'd1;
                  if (byte_done_s) begin
                     data_out_r       <= {shift_r[6:0], mosi_s};
                     data_out_ready_r <= 1'b1;
                     if (byte_count_r != COUNT_MAX) begin
                        byte_count_r <= byte_count_r + COUNT_ONE;
                     end else begin
                        byte_count_r <= byte_count_r;
                     end
                  end else begin
                     data_out_r   <= data_out_r;
                     byte_count_r <= byte_count_r;
                  end
               end else begin
                  shift_r   <= shift_r;
                  bit_cnt_r <= bit_cnt_r;
               end
            end
            default: begin
               bit_cnt_r <= 3'd0;
               shift_r   <= 8'h00;
            end
         endcase
      end
   end

   assign bus.data_out       = data_out_r;
   assign bus.data_out_ready = data_out_ready_r;
   assign bus.cs_n_out       = cs_s;
   assign bus.byte_count     = byte_count_r;
   assign bus.frame_error    = frame_error_r;

`ifdef SPI_MISO_EN
   logic [7:0] tx_r;
   logic       miso_r;

   // Response shifter: load at transaction start and byte boundaries, shift on SCLK fall
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         tx_r   <= 8'h00;
         miso_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cs_start_s) begin
                  tx_r   <= bus.tx_data;
                  miso_r <= bus.tx_data[7];
               end else begin
                  tx_r   <= tx_r;
                  miso_r <= 1'b0;
               end
            end
            ST_ACTIVE: begin
               if (cs_rise_s) begin
                  tx_r   <= tx_r;
                  miso_r <= 1'b0;
               end else if (byte_done_s) begin
                  tx_r   <= bus.tx_data;
                  miso_r <= bus.tx_data[7];
               end else if (sclk_fall_s) begin
                  tx_r   <= {tx_r[6:0], 1'b0};
                  miso_r <= tx_r[6];
               end else begin
                  tx_r   <= tx_r;
                  miso_r <= miso_r;
               end
            end
            default: begin
               tx_r   <= 8'h00;
               miso_r <= 1'b0;
            end
         endcase
      end
   end

   assign spi_miso = miso_r;
`else
   logic unused_tx_s;

   assign unused_tx_s = ^bus.tx_data;
   assign spi_miso    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_byte_receiver.sv
// ---------------------------------------------------------------------------
// tb_spi_byte_receiver
// Directed SPI host stimulus with a scoreboard: each byte sent and each
// expected framing error is queued when issued; an independent monitor pops
// and compares whenever the receiver strobes data_out_ready or frame_error.
// COUNT_WIDTH is reduced to 4 so the saturation case stays short.
// ---------------------------------------------------------------------------
module tb_spi_byte_receiver;

   localparam int CW   = 4;
   localparam int HALF = 6;

   logic clk_sys;
   logic reset;
   logic spi_sclk;
   logic spi_mosi;
   logic spi_cs_n;
   logic spi_miso;

   int checks;
   int errors;

   // scoreboard entry: bit 8 = 1 for frame error, 0 for data byte
   logic [8:0] exp_q[$];
   logic [7:0] miso_cap;

   spi_byte_receiver_if #(.COUNT_WIDTH(CW)) bus ();

   spi_byte_receiver #(
      .SYNC_STAGES (2),
      .COUNT_WIDTH (CW)
   ) dut (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_cs_n (spi_cs_n),
      .spi_miso (spi_miso),
      .bus      (bus)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic sclk_bit(input logic b);
      spi_mosi = b;
      wait_cycles(HALF);
      miso_cap = {miso_cap[6:0], spi_miso};
      spi_sclk = 1'b1;
      wait_cycles(HALF);
      spi_sclk = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic expect_strobe);
      if (expect_strobe) exp_q.push_back({1'b0, b});
      for (int i = 7; i >= 0; i--) sclk_bit(b[i]);
   endtask

   task automatic cs_begin();
      spi_cs_n = 1'b0;
      miso_cap = 8'h00;
   endtask

   task automatic cs_end();
      wait_cycles(HALF);
      spi_cs_n = 1'b1;
      wait_cycles(10);
   endtask

   // Monitor: pop and compare on every output strobe
   initial begin
      logic [8:0] e;
      forever begin
         @(negedge clk_sys);
         if (bus.data_out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", {23'd0, 1'b0, bus.data_out}, 32'h1ff);
            end else begin
               e = exp_q.pop_front();
               check("strobe_byte", {23'd0, 1'b0, bus.data_out}, {23'd0, e});
            end
         end
         if (bus.frame_error === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_frame_error", 32'h100, 32'h1ff);
            end else begin
               e = exp_q.pop_front();
               check("frame_error", 32'h100, {23'd0, e});
            end
         end
      end
   end

   // Stimulus
   initial begin
      logic [7:0] miso_exp;
      int         budget;
      checks      = 0;
      errors      = 0;
      reset       = 1'b1;
      spi_sclk    = 1'b0;
      spi_mosi    = 1'b0;
      spi_cs_n    = 1'b1;
      bus.tx_data = 8'h00;
      wait_cycles(3);
      check("rst_data_out", {24'd0, bus.data_out}, 32'h00);
      check("rst_ready", {31'd0, bus.data_out_ready}, 32'h0);
      check("rst_cs_n_out", {31'd0, bus.cs_n_out}, 32'h1);
      check("rst_byte_count", {28'd0, bus.byte_count}, 32'h0);
      check("rst_frame_error", {31'd0, bus.frame_error}, 32'h0);
      check("rst_miso", {31'd0, spi_miso}, 32'h0);
      reset = 1'b0;
      wait_cycles(8);

      // single byte
      cs_begin();
      send_byte(8'hA5, 1'b1);
      cs_end();
      check("t1_byte_count", {28'd0, bus.byte_count}, 32'h1);

      // five bytes back to back
      cs_begin();
      send_byte(8'h0A, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h03, 1'b1);
      wait_cycles(2);
      check("t2_all_strobes_seen", exp_q.size(), 32'd0);
      check("t2_cs_n_out_low", {31'd0, bus.cs_n_out}, 32'h0);
      cs_end();
      check("t2_cs_n_out_high", {31'd0, bus.cs_n_out}, 32'h1);
      check("t2_byte_count", {28'd0, bus.byte_count}, 32'h5);

      // 12 bits: one byte then a partial nibble
      cs_begin();
      send_byte(8'hFF, 1'b1);
      sclk_bit(1'b1);
      sclk_bit(1'b0);
      sclk_bit(1'b1);
      sclk_bit(1'b0);
      exp_q.push_back(9'h100);
      cs_end();
      check("t3_byte_count", {28'd0, bus.byte_count}, 32'h1);
      cs_begin();
      send_byte(8'h3C, 1'b1);
      cs_end();
      check("t3_next_byte_count", {28'd0, bus.byte_count}, 32'h1);

      // MISO response
      bus.tx_data = 8'hC3;
      cs_begin();
      send_byte(8'h00, 1'b1);
      cs_end();
`ifdef SPI_MISO_EN
      miso_exp = 8'hC3;
`else
      miso_exp = 8'h00;
`endif
      check("miso_bits", {24'd0, miso_cap}, {24'd0, miso_exp});

      // reset in the middle of a byte, CS held low across release
      cs_begin();
      sclk_bit(1'b1);
      sclk_bit(1'b0);
      sclk_bit(1'b1);
      sclk_bit(1'b0);
      reset = 1'b1;
      wait_cycles(1);
      check("mid_rst_data_out", {24'd0, bus.data_out}, 32'h00);
      check("mid_rst_byte_count", {28'd0, bus.byte_count}, 32'h0);
      wait_cycles(1);
      reset = 1'b0;
      send_byte(8'hFF, 1'b0);
      wait_cycles(8);
      check("post_rst_data_out", {24'd0, bus.data_out}, 32'h00);
      check("post_rst_byte_count", {28'd0, bus.byte_count}, 32'h0);
      cs_end();
      cs_begin();
      send_byte(8'h5A, 1'b1);
      cs_end();
      check("post_rst_new_frame", {24'd0, bus.data_out}, 32'h5A);

      // byte counter saturation
      cs_begin();
      for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b1);
      wait_cycles(4);
      check("sat_byte_count", {28'd0, bus.byte_count}, 32'hF);
      cs_end();
      cs_begin();
      wait_cycles(HALF);
      check("sat_cleared_on_cs_fall", {28'd0, bus.byte_count}, 32'h0);
      cs_end();

      budget = 0;
      while (exp_q.size() != 0 && budget < 50) begin
         wait_cycles(1);
         budget++;
      end
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
